// File: rtl/blake2s_msg_packer.sv
// Packs byte-serial message data into 64-byte little-endian BLAKE2s blocks with byte counter t.
// Latency: block valid 1 cycle after its closing byte. Backpressure: blk_ready_i low holds the block.
// BLAKE2S_PACKER_DBUF_EN: keep accepting the next block while one waits; ready_v_o drops only when both are full.
module blake2s_msg_packer #(
    parameter int BLOCK_BYTES = 64,
    parameter int T_W         = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_v_i,
    input  logic [7:0]               data_i,
    input  logic [5:0]               data_idx_i,
    input  logic                     block_first_i,
    input  logic                     block_last_i,
    output logic                     ready_v_o,
    output logic                     blk_v_o,
    input  logic                     blk_ready_i,
    output logic [8*BLOCK_BYTES-1:0] blk_m_o,
    output logic [T_W-1:0]           blk_t_o,
    output logic                     blk_first_o,
    output logic                     blk_last_o,
    output logic                     err_o
);

    typedef enum logic [1:0] {S_FILL, S_HOLD, S_FULL} state_t;

    state_t                   r_state, w_state_nxt;
    logic [8*BLOCK_BYTES-1:0] r_fill, w_fill_next;
    logic [5:0]               r_exp_idx;
    logic                     r_first_fill;
    logic [T_W-1:0]           r_t;
    logic                     r_err;
    logic [8*BLOCK_BYTES-1:0] r_blk_m;
    logic [T_W-1:0]           r_blk_t;
    logic                     r_blk_first, r_blk_last;

    logic                     w_accept, w_start, w_close, w_first, w_ld_new;
    logic [T_W-1:0]           w_t_close;

`ifdef BLAKE2S_PACKER_DBUF_EN
    logic [T_W-1:0]           r_pend_t;
    logic                     r_pend_first, r_pend_last;
    logic                     w_ld_pend, w_stash;

    assign ready_v_o = (r_state == S_FILL) || (r_state == S_HOLD);
    assign w_ld_pend = (r_state == S_FULL) && blk_ready_i;
    assign w_stash   = (r_state == S_HOLD) && !blk_ready_i && w_close;
`else
    assign ready_v_o = (r_state == S_FILL);
`endif

    assign blk_v_o     = (r_state != S_FILL);
    assign blk_m_o     = r_blk_m;
    assign blk_t_o     = r_blk_t;
    assign blk_first_o = r_blk_first;
    assign blk_last_o  = r_blk_last;
    assign err_o       = r_err;

    assign w_accept  = data_v_i && ready_v_o;
    assign w_start   = (r_exp_idx == 6'd0);
    assign w_close   = w_accept && ((data_idx_i == 6'd63) || block_last_i);
    assign w_first   = w_start ? block_first_i : r_first_fill;
    // A first block restarts the count; otherwise accumulate onto the running t.
    assign w_t_close = (w_first ? '0 : r_t) + T_W'(data_idx_i) + T_W'(1);
    assign w_ld_new  = w_close && ((r_state == S_FILL) || ((r_state == S_HOLD) && blk_ready_i));

    always_comb begin
        w_fill_next = w_start ? '0 : r_fill;
        w_fill_next[{data_idx_i, 3'b000} +: 8] = data_i;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: if (w_close) w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (blk_ready_i)  w_state_nxt = w_close ? S_HOLD : S_FILL;
                else if (w_close) w_state_nxt = S_FULL;
            end
            S_FULL: if (blk_ready_i) w_state_nxt = S_HOLD;
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_FILL;
            r_fill       <= '0;
            r_exp_idx    <= 6'd0;
            r_first_fill <= 1'b0;
            r_t          <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_fill       <= w_fill_next;
                r_first_fill <= w_first;
                r_exp_idx    <= w_close ? 6'd0 : data_idx_i + 6'd1;
                if (data_idx_i != r_exp_idx) r_err <= 1'b1;
            end
            if (w_close) r_t <= block_last_i ? '0 : w_t_close;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blk_m     <= '0;
            r_blk_t     <= '0;
            r_blk_first <= 1'b0;
            r_blk_last  <= 1'b0;
        end else if (w_ld_new) begin
            r_blk_m     <= w_fill_next;
            r_blk_t     <= w_t_close;
            r_blk_first <= w_first;
            r_blk_last  <= block_last_i;
        end
`ifdef BLAKE2S_PACKER_DBUF_EN
        else if (w_ld_pend) begin
            // The waiting block's bytes stay parked in the fill buffer.
            r_blk_m     <= r_fill;
            r_blk_t     <= r_pend_t;
            r_blk_first <= r_pend_first;
            r_blk_last  <= r_pend_last;
        end
`endif
    end

`ifdef BLAKE2S_PACKER_DBUF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_t     <= '0;
            r_pend_first <= 1'b0;
            r_pend_last  <= 1'b0;
        end else if (w_stash) begin
            r_pend_t     <= w_t_close;
            r_pend_first <= w_first;
            r_pend_last  <= block_last_i;
        end
    end
`endif

endmodule
